// File: rtl/JZJCoreFTypes.sv
// +----------------------------------------------------------------------------+
// | JZJCoreFTypes                                                              |
// | Shared types for the core: MMIO port numbering and arbiter FSM states.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package JZJCoreFTypes;

  localparam int MMIO_PORT_COUNT = 8;

  typedef logic [$clog2(MMIO_PORT_COUNT)-1:0] MmioPort_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } MmioArbState_t;

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// +----------------------------------------------------------------------------+
// | rr_priority_picker                                                         |
// | Finds the first set valid bit starting at ptr and wrapping modulo N.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_priority_picker #(
  parameter  int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] winner
);

  // Scan from farthest to nearest so the nearest match from ptr wins.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (valid[idx]) begin
        found  = 1'b1;
        winner = W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmio_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | mmio_port_arbiter                                                          |
// | Round-robin arbiter sharing the 8-port MMIO bank among NUM_REQ requesters. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mmio_port_arbiter
  import JZJCoreFTypes::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  MmioPort_t [NUM_REQ-1:0]        req_port,
  input  logic [NUM_REQ-1:0][31:0]       req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [31:0]                    rsp_rdata,
  output MmioPort_t                      mmio_port,
  output logic [31:0]                    mmio_wdata,
  output logic                           mmio_write_enable,
  input  logic [31:0]                    mmio_rdata,
  output logic                           busy
);

  localparam int REQ_IDX_W = $clog2(NUM_REQ);

  MmioArbState_t          r_state;
  logic [REQ_IDX_W-1:0]   r_ptr;
  logic [REQ_IDX_W-1:0]   r_grant;
  logic                   r_write;
  MmioPort_t              r_port;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rdata;

  logic                   w_found;
  logic [REQ_IDX_W-1:0]   w_winner;
  logic                   w_accept;

  rr_priority_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .valid  (req_valid),
    .ptr    (r_ptr),
    .found  (w_found),
    .winner (w_winner)
  );

  // req_ready is combinational, so gate it with reset to keep outputs quiet.
  assign w_accept          = (r_state == IDLE) && w_found && !reset;
  assign req_ready         = w_accept ? (NUM_REQ'(1) << w_winner) : '0;
  assign rsp_valid         = (r_state == RESPOND) ? (NUM_REQ'(1) << r_grant) : '0;
  assign mmio_write_enable = (r_state == ACCESS) && r_write;
  assign busy              = (r_state != IDLE);
  assign mmio_port         = r_port;
  assign mmio_wdata        = r_wdata;
  assign rsp_rdata         = r_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_write <= 1'b0;
      r_port  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_write <= req_write[w_winner];
            r_port  <= req_port[w_winner];
            r_wdata <= req_wdata[w_winner];
            r_ptr   <= (w_winner == REQ_IDX_W'(NUM_REQ - 1)) ? '0
                                                              : w_winner + REQ_IDX_W'(1);
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_rdata <= mmio_rdata;
          r_state <= RESPOND;
        end
        RESPOND: begin
          if (rsp_ready[r_grant]) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mmio_port_arbiter                                                       |
// | Directed vector bench for the round-robin MMIO port arbiter.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mmio_port_arbiter;
  import JZJCoreFTypes::*;

  localparam int NR = 2;

  logic                 clock;
  logic                 reset;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0]        req_write;
  MmioPort_t [NR-1:0]   req_port;
  logic [NR-1:0][31:0]  req_wdata;
  logic [NR-1:0]        rsp_valid;
  logic [NR-1:0]        rsp_ready;
  logic [31:0]          rsp_rdata;
  MmioPort_t            mmio_port;
  logic [31:0]          mmio_wdata;
  logic                 mmio_write_enable;
  logic [31:0]          mmio_rdata;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [2:0]  p0;
    logic [2:0]  p1;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [1:0]  rrdy;
    logic [1:0]  e_rr;
    logic [1:0]  e_rv;
    logic        e_we;
    logic [2:0]  e_port;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        e_busy;
  } vec_t;

  vec_t tbl [19];

  mmio_port_arbiter #(
    .NUM_REQ (NR)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_port          (req_port),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdata         (rsp_rdata),
    .mmio_port         (mmio_port),
    .mmio_wdata        (mmio_wdata),
    .mmio_write_enable (mmio_write_enable),
    .mmio_rdata        (mmio_rdata),
    .busy              (busy)
  );

  // Bank model: each port reads back a distinct constant.
  assign mmio_rdata = 32'h1000_0000 + {29'd0, mmio_port};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, " mmio_port"}, 32'(mmio_port), 32'h0);
    chk({tag, " mmio_wdata"}, mmio_wdata, 32'h0);
    chk({tag, " mmio_we"}, 32'(mmio_write_enable), 32'h0);
    chk({tag, " busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    tbl[0]  = '{2'b01, 2'b01, 3'd5, 3'd0, 32'hDEADBEEF, 32'h0, 2'b11, 2'b01, 2'b00, 1'b0, 3'd0, 32'h0,        32'h0,        1'b0};
    tbl[1]  = '{2'b00, 2'b01, 3'd5, 3'd0, 32'hDEADBEEF, 32'h0, 2'b11, 2'b00, 2'b00, 1'b1, 3'd5, 32'hDEADBEEF, 32'h0,        1'b1};
    tbl[2]  = '{2'b00, 2'b01, 3'd5, 3'd0, 32'hDEADBEEF, 32'h0, 2'b11, 2'b00, 2'b01, 1'b0, 3'd5, 32'hDEADBEEF, 32'h10000005, 1'b1};
    tbl[3]  = '{2'b10, 2'b00, 3'd0, 3'd3, 32'h0,        32'h0, 2'b11, 2'b10, 2'b00, 1'b0, 3'd5, 32'hDEADBEEF, 32'h10000005, 1'b0};
    tbl[4]  = '{2'b00, 2'b00, 3'd0, 3'd3, 32'h0,        32'h0, 2'b11, 2'b00, 2'b00, 1'b0, 3'd3, 32'h0,        32'h10000005, 1'b1};
    tbl[5]  = '{2'b00, 2'b00, 3'd0, 3'd3, 32'h0,        32'h0, 2'b11, 2'b00, 2'b10, 1'b0, 3'd3, 32'h0,        32'h10000003, 1'b1};
    tbl[6]  = '{2'b11, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b01, 2'b00, 1'b0, 3'd3, 32'h0,        32'h10000003, 1'b0};
    tbl[7]  = '{2'b11, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b00, 2'b00, 1'b0, 3'd1, 32'hA0000001, 32'h10000003, 1'b1};
    tbl[8]  = '{2'b11, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b00, 2'b01, 1'b0, 3'd1, 32'hA0000001, 32'h10000001, 1'b1};
    tbl[9]  = '{2'b11, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b10, 2'b00, 1'b0, 3'd1, 32'hA0000001, 32'h10000001, 1'b0};
    tbl[10] = '{2'b11, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b00, 2'b00, 1'b0, 3'd2, 32'hB0000002, 32'h10000001, 1'b1};
    tbl[11] = '{2'b11, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b00, 2'b10, 1'b0, 3'd2, 32'hB0000002, 32'h10000002, 1'b1};
    tbl[12] = '{2'b11, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b01, 2'b00, 1'b0, 3'd2, 32'hB0000002, 32'h10000002, 1'b0};
    tbl[13] = '{2'b11, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b00, 2'b00, 1'b0, 3'd1, 32'hA0000001, 32'h10000002, 1'b1};
    tbl[14] = '{2'b11, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b00, 2'b01, 1'b0, 3'd1, 32'hA0000001, 32'h10000001, 1'b1};
    tbl[15] = '{2'b11, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b10, 2'b00, 1'b0, 3'd1, 32'hA0000001, 32'h10000001, 1'b0};
    tbl[16] = '{2'b11, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b00, 2'b00, 1'b0, 3'd2, 32'hB0000002, 32'h10000001, 1'b1};
    tbl[17] = '{2'b11, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b00, 2'b10, 1'b0, 3'd2, 32'hB0000002, 32'h10000002, 1'b1};
    tbl[18] = '{2'b00, 2'b00, 3'd1, 3'd2, 32'hA0000001, 32'hB0000002, 2'b11, 2'b00, 2'b00, 1'b0, 3'd2, 32'hB0000002, 32'h10000002, 1'b0};

    // Reset asserted from time zero with both requesters pending.
    reset     = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_port  = '0;
    req_wdata = '0;
    rsp_ready = 2'b00;
    #8;
    chk_all_zero("init_reset");
    tick();
    reset = 1'b0;

    // Single write, single read, then two-way contention.
    for (int i = 0; i < 19; i++) begin
      req_valid    = tbl[i].valid;
      req_write    = tbl[i].write;
      req_port[0]  = tbl[i].p0;
      req_port[1]  = tbl[i].p1;
      req_wdata[0] = tbl[i].w0;
      req_wdata[1] = tbl[i].w1;
      rsp_ready    = tbl[i].rrdy;
      #4;
      chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tbl[i].e_rr));
      chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
      chk($sformatf("row%0d mmio_we", i),   32'(mmio_write_enable), 32'(tbl[i].e_we));
      chk($sformatf("row%0d mmio_port", i), 32'(mmio_port), 32'(tbl[i].e_port));
      chk($sformatf("row%0d mmio_wdata", i), mmio_wdata, tbl[i].e_wd);
      chk($sformatf("row%0d rsp_rdata", i), rsp_rdata, tbl[i].e_rd);
      chk($sformatf("row%0d busy", i),      32'(busy), 32'(tbl[i].e_busy));
      tick();
    end

    // Response backpressure on lane 0 while lane 1 waits; lane 1 rsp_ready ignored.
    req_valid    = 2'b11;
    req_write    = 2'b00;
    req_port[0]  = 3'd6;
    req_port[1]  = 3'd4;
    req_wdata[0] = 32'h11;
    req_wdata[1] = 32'h22;
    rsp_ready    = 2'b10;
    #4;
    chk("bp_grant req_ready", 32'(req_ready), 32'h1);
    tick();
    #4;
    chk("bp_access req_ready", 32'(req_ready), 32'h0);
    chk("bp_access mmio_port", 32'(mmio_port), 32'h6);
    tick();
    for (int k = 0; k < 5; k++) begin
      #4;
      chk($sformatf("bp_hold%0d rsp_valid", k), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp_hold%0d rsp_rdata", k), rsp_rdata, 32'h10000006);
      chk($sformatf("bp_hold%0d req_ready", k), 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 2'b01;
    #4;
    chk("bp_release rsp_valid", 32'(rsp_valid), 32'h1);
    chk("bp_release req_ready", 32'(req_ready), 32'h0);
    tick();
    rsp_ready = 2'b00;
    #4;
    chk("bp_next req_ready", 32'(req_ready), 32'h2);
    tick();
    #4;
    chk("rst_access mmio_port", 32'(mmio_port), 32'h4);
    chk("rst_access mmio_we", 32'(mmio_write_enable), 32'h0);
    tick();
    #4;
    chk("rst_respond rsp_valid", 32'(rsp_valid), 32'h2);
    chk("rst_respond rsp_rdata", rsp_rdata, 32'h10000004);

    // Reset mid-cycle while responding: response must vanish at once.
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    tick();
    reset = 1'b0;
    #4;
    chk("post_reset req_ready", 32'(req_ready), 32'h1);
    chk("post_reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post_reset busy", 32'(busy), 32'h0);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    tick();
    for (int k = 0; k < 3; k++) begin
      #4;
      chk($sformatf("no_stale%0d rsp_valid", k), 32'(rsp_valid), 32'h0);
      chk($sformatf("no_stale%0d busy", k), 32'(busy), 32'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
